fu_issue_ctrl: RTL and testbench
================================

Name: fu_issue_ctrl

Overview:
- Execution-lane scheduler between the reservation station issue ports and the CDB; one lane per issue way.
- Tracks per-lane occupancy for fixed or multi-cycle ops and drives `fu_occupied`, which feeds the RS `ALU_occupied` input.
- Arbitrates the `WAYS` CDB write-back slots between completed lanes and one external write-back requester (load unit).
- Control only: data muxing into the CDB is done outside, selected by `cdb_src`.

Parameters:
- `WAYS`, default 2: issue lanes = CDB slots.
- `PRF`, default 64: physical registers; `PRF_W = $clog2(PRF)`.
- `MAX_LAT`, default 4: maximum execution latency; `LAT_W = $clog2(MAX_LAT+1)`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `squash`  in  1  synchronous flush of all lanes (mispredict).
- `issue_valid`  in  WAYS  op issued to lane i this cycle.
- `issue_latency`  in  WAYS x LAT_W  execution cycles of issued op (1..MAX_LAT).
- `issue_prf_idx`  in  WAYS x PRF_W  destination PRF index.
- `ext_req`  in  1  external write-back request.
- `ext_prf_idx`  in  PRF_W  external destination PRF index.
- `ext_gnt`  out  1  external request granted this cycle.
- `fu_occupied`  out  WAYS  lane i cannot accept issue this cycle.
- `cdb_valid`  out  WAYS  CDB slot valid, contiguous from LSB.
- `cdb_prf_idx`  out  WAYS x PRF_W  per-slot PRF index.
- `cdb_src`  out  WAYS x $clog2(WAYS+1)  slot source: value `WAYS` = external, else lane number.
- `protocol_err`  out  1  one-cycle pulse: issue to an occupied lane.

Behaviour:
- Per-lane registered FSM with states `IDLE`, `BUSY`, `WAIT`, plus `cnt[LAT_W]` and `prf[PRF_W]`.
- Issue in cycle t is sampled at the closing edge. The write-back request becomes visible in cycle t+L.
  - L=1: next state is `WAIT`.
  - L>1: next state is `BUSY` with `cnt = L-2`.
  - L=0 is treated as 1.
  - L > `MAX_LAT` is saturated to `MAX_LAT`.
- `BUSY`: if `cnt==0`, next state is `WAIT`; otherwise `cnt` decrements.
- `WAIT`: the lane requests the CDB.
  - If granted: next state is `IDLE`. A simultaneous issue overrides this and loads the new op (back-to-back).
  - If not granted: the lane stays in `WAIT` and holds `prf`.
- `fu_occupied[i] = (state==BUSY) | (state==WAIT & ~lane_gnt[i])`.
  - `lane_gnt` depends only on registered state, `ext_req` and `rr_ptr`, never on `issue_*`, so there is no combinational loop through the RS.
- Arbitration is combinational within the cycle:
  - Slot 0 goes to `ext_req` if asserted (loads have priority).
  - Remaining slots go to `WAIT` lanes in round-robin order starting at `rr_ptr`.
  - Granted requests are packed LSB-first; `cdb_valid` is always of the form 0…01…1.
- `rr_ptr` register (`$clog2(WAYS)` bits): when at least one lane is granted, it updates to (last granted lane + 1) mod `WAYS`; otherwise it holds.
- Issue to a lane with `fu_occupied=1`: the issue is ignored, the lane state is unchanged, and `protocol_err=1` next cycle.
- `squash`:
  - In the squash cycle, lane grants are forced to 0. `ext_req` is still arbitrated normally.
  - `issue_valid` is ignored in that cycle.
  - Next state: all lanes `IDLE`; `rr_ptr` holds.
- Reset:
  - While `reset` is high: `cdb_valid=0`, `ext_gnt=0`, `fu_occupied` all ones, `protocol_err=0`.
  - After reset: all lanes `IDLE`, `rr_ptr=0`, `cnt=0`, `prf=0`.
  - Reset takes priority over `squash` and issue. Reset mid-operation discards all pending results.
- Unused slots drive `cdb_prf_idx=0` and `cdb_src=0`.

Test Plan:
1. Reset for 2 cycles, then release → cycle after release: `fu_occupied=00`, `cdb_valid=00`, `ext_gnt=0`.
2. Cycle 0: issue lane0, L=1, prf 5. Cycle 1: issue lane0, L=1, prf 6.
   → cycle 1: `cdb_valid=01`, `cdb_prf_idx[0]=5`, `cdb_src[0]=0`, `fu_occupied[0]=0`.
   → cycle 2: `cdb_prf_idx[0]=6`.
3. Cycle 0: issue lane1, L=4, prf 9 → `fu_occupied[1]=1` in cycles 1–3; cycle 4: `cdb_valid=01`, `cdb_prf_idx[0]=9`, `cdb_src[0]=1`.
4. Both lanes in `WAIT` (prf 3, 4), `ext_req=1` with prf 7, `rr_ptr=0`:
   → slot0 = {7, src 2}, slot1 = {3, src 0}, `fu_occupied=10`.
   → next cycle with `ext_req=0`: slot0 = {4, src 1}, `rr_ptr` becomes 0.
5. Lane0 issued L=4 in cycle 0, `squash` high in cycle 2 → `fu_occupied[0]=0` from cycle 3, no `cdb_valid` for lane0 in cycle 4.
6. Lane1 `BUSY` with `issue_valid[1]=1` → `protocol_err=1` next cycle, original result still broadcast at its scheduled cycle with its original prf.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: per-lane execution occupancy tracking and CDB
// write-back slot arbitration between finished lanes and the load unit.
module fu_issue_ctrl #(
    parameter int WAYS    = 2,
    parameter int PRF     = 64,
    parameter int MAX_LAT = 4,
    localparam int PRF_W  = $clog2(PRF),
    localparam int LAT_W  = $clog2(MAX_LAT + 1),
    localparam int SRC_W  = $clog2(WAYS + 1),
    localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic [WAYS-1:0]       issue_valid,
    input  logic [WAYS*LAT_W-1:0] issue_latency,
    input  logic [WAYS*PRF_W-1:0] issue_prf_idx,
    input  logic                  ext_req,
    input  logic [PRF_W-1:0]      ext_prf_idx,
    output logic                  ext_gnt,
    output logic [WAYS-1:0]       fu_occupied,
    output logic [WAYS-1:0]       cdb_valid,
    output logic [WAYS*PRF_W-1:0] cdb_prf_idx,
    output logic [WAYS*SRC_W-1:0] cdb_src,
    output logic                  protocol_err
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT
    } lane_st_e;

    lane_st_e         state_q [WAYS];
    lane_st_e         state_d [WAYS];
    logic [LAT_W-1:0] cnt_q   [WAYS];
    logic [LAT_W-1:0] cnt_d   [WAYS];
    logic [PRF_W-1:0] prf_q   [WAYS];
    logic [PRF_W-1:0] prf_d   [WAYS];
    logic [RR_W-1:0]  rr_ptr;
    logic [RR_W-1:0]  rr_d;
    logic             err_q;
    logic             err_d;
    logic [WAYS-1:0]  lane_req;
    logic [WAYS-1:0]  lane_gnt;
    logic [WAYS-1:0]  occ;

    // Lane requests come only from registered state; squash mutes them.
    always_comb begin
        lane_req = '0;
        for (int i = 0; i < WAYS; i++) begin
            lane_req[i] = (state_q[i] == WAIT) && !squash;
        end
    end

    // Slot 0 to the load unit first, then waiting lanes round-robin, packed LSB-first.
    always_comb begin
        int slot;
        int lane;
        int last;
        logic any;
        slot        = 0;
        lane        = 0;
        last        = 0;
        any         = 1'b0;
        lane_gnt    = '0;
        ext_gnt     = 1'b0;
        cdb_valid   = '0;
        cdb_prf_idx = '0;
        cdb_src     = '0;
        if (!reset) begin
            if (ext_req) begin
                ext_gnt                  = 1'b1;
                cdb_valid[0]             = 1'b1;
                cdb_prf_idx[PRF_W-1:0]   = ext_prf_idx;
                cdb_src[SRC_W-1:0]       = SRC_W'(WAYS);
                slot                     = 1;
            end
            for (int k = 0; k < WAYS; k++) begin
                lane = (int'(rr_ptr) + k) % WAYS;
                if (lane_req[lane] && slot < WAYS) begin
                    lane_gnt[lane]                   = 1'b1;
                    cdb_valid[slot]                  = 1'b1;
                    cdb_prf_idx[slot*PRF_W +: PRF_W] = prf_q[lane];
                    cdb_src[slot*SRC_W +: SRC_W]     = SRC_W'(lane);
                    slot                             = slot + 1;
                    last                             = lane;
                    any                              = 1'b1;
                end
            end
        end
        rr_d = any ? RR_W'((last + 1) % WAYS) : rr_ptr;
    end

    // A lane is free when idle or when its result leaves on the CDB this cycle.
    always_comb begin
        occ = '0;
        for (int i = 0; i < WAYS; i++) begin
            occ[i] = (state_q[i] == BUSY) ||
                     ((state_q[i] == WAIT) && !lane_gnt[i]);
        end
        fu_occupied  = reset ? '1 : occ;
        protocol_err = err_q && !reset;
    end

    // Per-lane next state: squash, then accepted issue, then countdown/write-back.
    always_comb begin
        logic [LAT_W-1:0] lat;
        lat   = '0;
        err_d = !squash && (|(issue_valid & occ));
        for (int i = 0; i < WAYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            prf_d[i]   = prf_q[i];
            lat        = issue_latency[i*LAT_W +: LAT_W];
            if (lat == '0) begin
                lat = LAT_W'(1);
            end else if (lat > LAT_W'(MAX_LAT)) begin
                lat = LAT_W'(MAX_LAT);
            end
            if (squash) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (issue_valid[i] && !occ[i]) begin
                prf_d[i] = issue_prf_idx[i*PRF_W +: PRF_W];
                if (lat == LAT_W'(1)) begin
                    state_d[i] = WAIT;
                    cnt_d[i]   = '0;
                end else begin
                    state_d[i] = BUSY;
                    cnt_d[i]   = lat - LAT_W'(2);
                end
            end else begin
                unique case (state_q[i])
                    BUSY: begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = WAIT;
                        end else begin
                            cnt_d[i] = cnt_q[i] - LAT_W'(1);
                        end
                    end
                    WAIT: begin
                        if (lane_gnt[i]) begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State registers; reset drops every pending result.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                prf_q[i]   <= '0;
            end
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                prf_q[i]   <= prf_d[i];
            end
            rr_ptr <= rr_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// tb_fu_issue_ctrl: timestamp-based lane model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fu_issue_ctrl;
    localparam int WAYS = 2;
    localparam int PRF_W = 6;
    localparam int LAT_W = 3;
    localparam int MAXL = 4;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [1:0]  issue_valid;
    logic [5:0]  issue_latency;
    logic [11:0] issue_prf_idx;
    logic        ext_req;
    logic [5:0]  ext_prf_idx;
    logic        ext_gnt;
    logic [1:0]  fu_occupied;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_prf_idx;
    logic [3:0]  cdb_src;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    fu_issue_ctrl #(.WAYS(2), .PRF(64), .MAX_LAT(4)) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .issue_valid(issue_valid),
        .issue_latency(issue_latency),
        .issue_prf_idx(issue_prf_idx),
        .ext_req(ext_req),
        .ext_prf_idx(ext_prf_idx),
        .ext_gnt(ext_gnt),
        .fu_occupied(fu_occupied),
        .cdb_valid(cdb_valid),
        .cdb_prf_idx(cdb_prf_idx),
        .cdb_src(cdb_src),
        .protocol_err(protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a lane holds at most one result, due at an absolute cycle.
    bit         m_pend [WAYS];
    int         m_due  [WAYS];
    logic [5:0] m_prf  [WAYS];
    int         m_rr = 0;
    bit         m_err = 0;
    int         cyc = 0;
    logic [1:0] m_gnt = '0;
    logic [1:0] m_occ = 2'b11;
    int         m_rr_next = 0;

    initial begin
        int slot;
        int l;
        int last;
        int eff;
        bit any;
        logic [1:0]  ev;
        logic [11:0] ep;
        logic [3:0]  es;
        logic        eg;
        logic [1:0]  eo;
        for (int i = 0; i < WAYS; i++) begin
            m_pend[i] = 0;
            m_due[i]  = 0;
            m_prf[i]  = '0;
        end
        forever begin
            @(posedge clock);
            if (reset) begin
                for (int i = 0; i < WAYS; i++) m_pend[i] = 0;
                m_rr  = 0;
                m_err = 0;
            end else begin
                m_err = !squash && (|(issue_valid & m_occ));
                for (int i = 0; i < WAYS; i++) begin
                    if (squash) begin
                        m_pend[i] = 0;
                    end else begin
                        if (m_gnt[i]) m_pend[i] = 0;
                        if (issue_valid[i] && !m_occ[i]) begin
                            eff = int'(issue_latency[i*LAT_W +: LAT_W]);
                            if (eff < 1) eff = 1;
                            if (eff > MAXL) eff = MAXL;
                            m_pend[i] = 1;
                            m_due[i]  = cyc + eff;
                            m_prf[i]  = issue_prf_idx[i*PRF_W +: PRF_W];
                        end
                    end
                end
                m_rr = m_rr_next;
            end
            cyc++;
            @(negedge clock);
            ev = '0; ep = '0; es = '0; eg = 1'b0; eo = 2'b11;
            m_gnt = '0; any = 0; last = 0; slot = 0;
            if (!reset) begin
                if (ext_req) begin
                    eg = 1'b1; ev[0] = 1'b1; ep[5:0] = ext_prf_idx;
                    es[1:0] = 2'd2; slot = 1;
                end
                for (int k = 0; k < WAYS; k++) begin
                    l = (m_rr + k) % WAYS;
                    if (!squash && m_pend[l] && cyc >= m_due[l] && slot < WAYS) begin
                        m_gnt[l] = 1'b1;
                        ev[slot] = 1'b1;
                        ep[slot*PRF_W +: PRF_W] = m_prf[l];
                        es[slot*2 +: 2] = l[1:0];
                        slot++;
                        last = l;
                        any = 1;
                    end
                end
                for (int i = 0; i < WAYS; i++) eo[i] = m_pend[i] && !m_gnt[i];
            end
            m_occ = eo;
            m_rr_next = any ? (last + 1) % WAYS : m_rr;
            chk("m_occ", 32'(fu_occupied), 32'(eo));
            chk("m_valid", 32'(cdb_valid), 32'(ev));
            chk("m_prf", 32'(cdb_prf_idx), 32'(ep));
            chk("m_src", 32'(cdb_src), 32'(es));
            chk("m_gnt", 32'(ext_gnt), 32'(eg));
            chk("m_err", 32'(protocol_err), 32'(!reset && m_err));
        end
    end

    task automatic clr();
        squash = 0; issue_valid = '0; issue_latency = '0;
        issue_prf_idx = '0; ext_req = 0; ext_prf_idx = '0;
    endtask

    task automatic iss(input int lane, input int lat, input int prf);
        issue_valid[lane] = 1'b1;
        issue_latency[lane*LAT_W +: LAT_W] = 3'(lat);
        issue_prf_idx[lane*PRF_W +: PRF_W] = 6'(prf);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        @(negedge clock);
        chk("rst_occ", 32'(fu_occupied), 32'h3);
        chk("rst_valid", 32'(cdb_valid), 32'h0);
        chk("rst_gnt", 32'(ext_gnt), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t1_occ", 32'(fu_occupied), 32'h0);
        chk("t1_valid", 32'(cdb_valid), 32'h0);
        chk("t1_gnt", 32'(ext_gnt), 32'h0);
        step();

        // back-to-back single-cycle ops on lane 0
        iss(0, 1, 5);
        @(negedge clock); step();
        clr(); iss(0, 1, 6);
        @(negedge clock);
        chk("t2_valid", 32'(cdb_valid), 32'h1);
        chk("t2_prf", 32'(cdb_prf_idx[5:0]), 32'd5);
        chk("t2_src", 32'(cdb_src[1:0]), 32'd0);
        chk("t2_occ0", 32'(fu_occupied[0]), 32'd0);
        step();
        clr();
        @(negedge clock);
        chk("t2_prf2", 32'(cdb_prf_idx[5:0]), 32'd6);
        step();

        // four-cycle op on lane 1
        iss(1, 4, 9);
        @(negedge clock); step();
        clr();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("t3_busy", 32'(fu_occupied[1]), 32'd1);
            step();
        end
        @(negedge clock);
        chk("t3_valid", 32'(cdb_valid), 32'h1);
        chk("t3_prf", 32'(cdb_prf_idx[5:0]), 32'd9);
        chk("t3_src", 32'(cdb_src[1:0]), 32'd1);
        step();

        // load priority and round-robin
        iss(0, 1, 3); iss(1, 1, 4);
        @(negedge clock); step();
        clr(); ext_req = 1; ext_prf_idx = 6'd7; iss(1, 1, 30);
        @(negedge clock);
        chk("t4_valid", 32'(cdb_valid), 32'h3);
        chk("t4_prf", 32'(cdb_prf_idx), 32'({6'd3, 6'd7}));
        chk("t4_src", 32'(cdb_src), 32'h2);
        chk("t4_occ", 32'(fu_occupied), 32'h2);
        chk("t4_gnt", 32'(ext_gnt), 32'h1);
        step();
        clr();
        @(negedge clock);
        chk("t4b_valid", 32'(cdb_valid), 32'h1);
        chk("t4b_prf", 32'(cdb_prf_idx[5:0]), 32'd4);
        chk("t4b_src", 32'(cdb_src[1:0]), 32'd1);
        chk("t4b_err", 32'(protocol_err), 32'd1);
        step();
        iss(0, 1, 14); iss(1, 1, 15);
        @(negedge clock); step();
        clr();
        @(negedge clock);
        chk("t4c_valid", 32'(cdb_valid), 32'h3);
        chk("t4c_src", 32'(cdb_src), 32'h4);
        chk("t4c_prf", 32'(cdb_prf_idx), 32'({6'd15, 6'd14}));
        step();

        // squash mid-flight
        iss(0, 4, 11);
        @(negedge clock); step();
        clr();
        @(negedge clock); step();
        squash = 1; ext_req = 1; ext_prf_idx = 6'd20; iss(1, 1, 21);
        @(negedge clock);
        chk("t5_valid", 32'(cdb_valid), 32'h1);
        chk("t5_prf", 32'(cdb_prf_idx[5:0]), 32'd20);
        chk("t5_src", 32'(cdb_src[1:0]), 32'd2);
        chk("t5_occ", 32'(fu_occupied), 32'h1);
        step();
        clr();
        @(negedge clock);
        chk("t5_occ2", 32'(fu_occupied), 32'h0);
        step();
        @(negedge clock);
        chk("t5_none", 32'(cdb_valid), 32'h0);
        step();

        // issue into a busy lane
        iss(1, 3, 12);
        @(negedge clock); step();
        clr(); iss(1, 1, 13);
        @(negedge clock);
        chk("t6_occ", 32'(fu_occupied[1]), 32'd1);
        step();
        clr();
        @(negedge clock);
        chk("t6_err", 32'(protocol_err), 32'd1);
        step();
        @(negedge clock);
        chk("t6_valid", 32'(cdb_valid), 32'h1);
        chk("t6_prf", 32'(cdb_prf_idx[5:0]), 32'd12);
        chk("t6_src", 32'(cdb_src[1:0]), 32'd1);
        chk("t6_err0", 32'(protocol_err), 32'd0);
        step();

        // latency 0 and latency above the maximum
        iss(0, 0, 21); iss(1, 7, 22);
        @(negedge clock); step();
        clr();
        @(negedge clock);
        chk("t7_valid", 32'(cdb_valid), 32'h1);
        chk("t7_prf", 32'(cdb_prf_idx[5:0]), 32'd21);
        step();
        @(negedge clock); step();
        @(negedge clock);
        chk("t7_busy", 32'(fu_occupied[1]), 32'd1);
        step();
        @(negedge clock);
        chk("t7_sat_prf", 32'(cdb_prf_idx[5:0]), 32'd22);
        chk("t7_sat_src", 32'(cdb_src[1:0]), 32'd1);
        step();

        // reset mid-operation
        iss(0, 3, 25);
        @(negedge clock); step();
        clr(); reset = 1;
        @(negedge clock);
        chk("t8_occ", 32'(fu_occupied), 32'h3);
        chk("t8_valid", 32'(cdb_valid), 32'h0);
        step();
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("t8_gone", 32'(cdb_valid), 32'h0);
            step();
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
